// File: rtl/syn_gpu_pxl_blend.sv
// Alpha-blend stage in front of the GPU pixel gateway: read-modify-write for translucent pixels.
// Optional read-return timeout enabled by defining SYN_GPU_PXL_BLEND_RD_TMO_EN.
module syn_gpu_pxl_blend #(
  parameter int P_X_W      = 10,
  parameter int P_Y_W      = 9,
  parameter int P_CANVAS_W = 640,
  parameter int P_CANVAS_H = 480,
  parameter int P_H_W      = 3,
  parameter int P_S_W      = 2,
  parameter int P_I_W      = 3,
  parameter int P_RD_TMO   = 64,
  localparam int P_PXL_W   = P_H_W + P_S_W + P_I_W
) (
  input  logic               clk_ir,
  input  logic               rst_sync,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_PXL_W-1:0] in_pxl,
  input  logic [3:0]         in_alpha,
  input  logic [P_X_W-1:0]   in_posx,
  input  logic [P_Y_W-1:0]   in_posy,
  output logic [P_PXL_W-1:0] gw_pxl,
  output logic               gw_wr_valid,
  output logic               gw_rd_valid,
  output logic [P_X_W-1:0]   gw_posx,
  output logic [P_Y_W-1:0]   gw_posy,
  input  logic               gw_ready,
  input  logic               rd_valid,
  input  logic [P_PXL_W-1:0] rd_pxl,
  output logic               busy,
  output logic               err_rd_tmo
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ} state_t;

  localparam int BW    = P_I_W + 5;
  localparam int HS_W  = P_H_W + P_S_W;
  localparam logic [P_X_W-1:0] CANVAS_W_L = P_X_W'(P_CANVAS_W);
  localparam logic [P_Y_W-1:0] CANVAS_H_L = P_Y_W'(P_CANVAS_H);

  state_t             state;
  logic [P_PXL_W-1:0] job_pxl;
  logic [3:0]         job_alpha;

  logic [BW-1:0]      i_old_w, i_new_w, a_w, a_inv_w, i_sum;
  logic [P_PXL_W-1:0] blend_pxl;
  logic               job_drop;

  // NOTE: always_comb gives every output a value on every path first, so no latch is inferred.
  always_comb begin
    i_old_w   = BW'(rd_pxl[P_I_W-1:0]);
    i_new_w   = BW'(job_pxl[P_I_W-1:0]);
    a_w       = BW'(job_alpha);
    a_inv_w   = BW'(16) - a_w;
    i_sum     = i_old_w * a_inv_w + i_new_w * a_w + BW'(8);
    blend_pxl = {rd_pxl[P_PXL_W-1:P_I_W], i_sum[P_I_W+3:4]};
    // Opacity of one half or more takes hue and saturation from the new pixel.
    if (job_alpha >= 4'd8) blend_pxl[P_PXL_W-1:P_I_W] = job_pxl[P_PXL_W-1:P_I_W];
  end

  assign job_drop = (in_alpha == 4'd0) || (in_posx >= CANVAS_W_L) || (in_posy >= CANVAS_H_L);
  assign busy     = (state != ST_IDLE);

`ifdef SYN_GPU_PXL_BLEND_RD_TMO_EN
  localparam int TMO_W = $clog2(P_RD_TMO) + 1;
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err_rd_tmo = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      job_pxl     <= '0;
      job_alpha   <= '0;
      gw_pxl      <= '0;
      gw_wr_valid <= 1'b0;
      gw_rd_valid <= 1'b0;
      gw_posx     <= '0;
      gw_posy     <= '0;
`ifdef SYN_GPU_PXL_BLEND_RD_TMO_EN
      tmo_cnt     <= '0;
      err_rd_tmo  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            job_pxl   <= in_pxl;
            job_alpha <= in_alpha;
            if (!job_drop) begin
              in_ready <= 1'b0;
              gw_posx  <= in_posx;
              gw_posy  <= in_posy;
              if (in_alpha == 4'd15) begin
                state       <= ST_WR_REQ;
                gw_pxl      <= in_pxl;
                gw_wr_valid <= 1'b1;
              end else begin
                state       <= ST_RD_REQ;
                gw_rd_valid <= 1'b1;
              end
            end
          end
        end
        ST_RD_REQ: begin
          if (gw_ready) begin
            gw_rd_valid <= 1'b0;
            state       <= ST_RD_WAIT;
`ifdef SYN_GPU_PXL_BLEND_RD_TMO_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        ST_RD_WAIT: begin
          if (rd_valid) begin
            gw_pxl      <= blend_pxl;
            gw_wr_valid <= 1'b1;
            state       <= ST_WR_REQ;
          end
`ifdef SYN_GPU_PXL_BLEND_RD_TMO_EN
          else if (tmo_cnt == TMO_W'(P_RD_TMO - 1)) begin
            err_rd_tmo <= 1'b1;
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            gw_posx    <= '0;
            gw_posy    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_WR_REQ: begin
          if (gw_ready) begin
            gw_wr_valid <= 1'b0;
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            gw_posx     <= '0;
            gw_posy     <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  logic unused_hs;
  assign unused_hs = ^HS_W;

endmodule

// File: tb/tb_syn_gpu_pxl_blend.sv
// Self-checking bench for syn_gpu_pxl_blend: directed jobs plus randomized jobs against a
// spec-level blend model and a gateway transaction monitor.
module tb_syn_gpu_pxl_blend;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int PW  = 8;

  logic           clk_ir = 1'b0;
  logic           rst_sync;
  logic           in_valid;
  logic           in_ready;
  logic [PW-1:0]  in_pxl;
  logic [3:0]     in_alpha;
  logic [X_W-1:0] in_posx;
  logic [Y_W-1:0] in_posy;
  logic [PW-1:0]  gw_pxl;
  logic           gw_wr_valid;
  logic           gw_rd_valid;
  logic [X_W-1:0] gw_posx;
  logic [Y_W-1:0] gw_posy;
  logic           gw_ready;
  logic           rd_valid;
  logic [PW-1:0]  rd_pxl;
  logic           busy;
  logic           err_rd_tmo;

  syn_gpu_pxl_blend dut (
    .clk_ir(clk_ir), .rst_sync(rst_sync),
    .in_valid(in_valid), .in_ready(in_ready), .in_pxl(in_pxl), .in_alpha(in_alpha),
    .in_posx(in_posx), .in_posy(in_posy),
    .gw_pxl(gw_pxl), .gw_wr_valid(gw_wr_valid), .gw_rd_valid(gw_rd_valid),
    .gw_posx(gw_posx), .gw_posy(gw_posy), .gw_ready(gw_ready),
    .rd_valid(rd_valid), .rd_pxl(rd_pxl), .busy(busy), .err_rd_tmo(err_rd_tmo)
  );

  always #5 clk_ir = ~clk_ir;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;

  // Gateway-side view: count accepted handshakes and illegal overlap.
  always @(posedge clk_ir) begin
    if (!rst_sync) begin
      if (gw_rd_valid && gw_ready) rd_cnt++;
      if (gw_wr_valid && gw_ready) wr_cnt++;
      if (gw_rd_valid && gw_wr_valid) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Spec-level blend: intensity is a rounded weighted mean, h/s chosen by opacity.
  function automatic logic [7:0] blend_ref(input logic [7:0] old_p, input logic [7:0] new_p,
                                           input int a);
    int i_old, i_new, i_out, hs;
    i_old = old_p % 8;
    i_new = new_p % 8;
    i_out = (i_old * (16 - a) + i_new * a + 8) / 16;
    hs    = (a >= 8) ? (new_p / 8) : (old_p / 8);
    return 8'(hs * 8 + i_out);
  endfunction

  task automatic do_job(input string tag, input logic [7:0] pxl, input int a, input int x,
                        input int y, input logic [7:0] old_p, input int stall, input int rd_lat);
    int rd0, wr0;
    bit drop;
    logic [7:0] exp_pxl;
    rd0  = rd_cnt;
    wr0  = wr_cnt;
    drop = (a == 0) || (x >= 640) || (y >= 480);
    check({tag, "_ready_before"}, in_ready, 1);
    in_valid = 1'b1;
    in_pxl   = pxl;
    in_alpha = 4'(a);
    in_posx  = X_W'(x);
    in_posy  = Y_W'(y);
    gw_ready = (stall == 0);
    @(negedge clk_ir);
    in_valid = 1'b0;
    in_pxl   = 8'($urandom);
    in_alpha = 4'($urandom);
    in_posx  = X_W'($urandom);
    in_posy  = Y_W'($urandom);
    if (drop) begin
      repeat (2) @(negedge clk_ir);
      check({tag, "_drop_busy"}, busy, 0);
      check({tag, "_drop_ready"}, in_ready, 1);
      check({tag, "_drop_posx"}, gw_posx, 0);
      check({tag, "_drop_reqs"}, (rd_cnt - rd0) + (wr_cnt - wr0), 0);
      gw_ready = 1'b1;
      return;
    end
    if (a != 15) begin
      for (int i = 0; i <= stall; i++) begin
        check({tag, "_rd_valid"}, gw_rd_valid, 1);
        check({tag, "_rd_posxy"}, {gw_wr_valid, gw_posx, gw_posy}, {1'b0, X_W'(x), Y_W'(y)});
        if (i == stall) gw_ready = 1'b1;
        @(negedge clk_ir);
      end
      gw_ready = (stall == 0);
      check({tag, "_wait_state"}, {busy, gw_rd_valid, gw_wr_valid}, 3'b100);
      repeat (rd_lat) @(negedge clk_ir);
      rd_valid = 1'b1;
      rd_pxl   = old_p;
      @(negedge clk_ir);
      rd_valid = 1'b0;
      rd_pxl   = 8'($urandom);
      exp_pxl  = blend_ref(old_p, pxl, a);
    end else begin
      exp_pxl = pxl;
    end
    for (int i = 0; i <= stall; i++) begin
      check({tag, "_wr_valid"}, {gw_wr_valid, gw_rd_valid}, 2'b10);
      check({tag, "_wr_pxl"}, gw_pxl, exp_pxl);
      check({tag, "_wr_posxy"}, {gw_posx, gw_posy}, {X_W'(x), Y_W'(y)});
      if (i == stall) gw_ready = 1'b1;
      @(negedge clk_ir);
    end
    check({tag, "_done_ready"}, {in_ready, busy, gw_wr_valid}, 3'b100);
    check({tag, "_done_pos"}, {gw_posx, gw_posy}, 0);
    check({tag, "_rd_count"}, rd_cnt - rd0, (a != 15) ? 1 : 0);
    check({tag, "_wr_count"}, wr_cnt - wr0, 1);
  endtask

  initial begin
    int a, x, y;
    rst_sync = 1'b1;
    in_valid = 1'b0;
    in_pxl   = '0;
    in_alpha = '0;
    in_posx  = '0;
    in_posy  = '0;
    gw_ready = 1'b1;
    rd_valid = 1'b0;
    rd_pxl   = '0;
    repeat (3) @(negedge clk_ir);
    check("rst_ready", in_ready, 1);
    check("rst_outs", {busy, gw_wr_valid, gw_rd_valid, err_rd_tmo}, 0);
    check("rst_gw", {gw_pxl, gw_posx, gw_posy}, 0);
    rst_sync = 1'b0;
    @(negedge clk_ir);

    do_job("opaque", 8'hFF, 15, 10, 20, 8'h00, 0, 0);
    do_job("blend_new_hs", {3'd2, 2'd3, 3'd7}, 8, 100, 200, {3'd5, 2'd1, 3'd0}, 0, 0);
    check("blend_new_hs_ref", blend_ref({3'd5, 2'd1, 3'd0}, {3'd2, 2'd3, 3'd7}, 8),
          {3'd2, 2'd3, 3'd4});
    do_job("blend_old_hs", {3'd2, 2'd3, 3'd2}, 4, 639, 479, {3'd5, 2'd1, 3'd6}, 0, 2);
    do_job("drop_x", 8'hAB, 15, 640, 5, 8'h00, 0, 0);
    do_job("drop_y", 8'hAB, 9, 5, 480, 8'h00, 0, 0);
    do_job("drop_alpha", 8'hAB, 0, 5, 5, 8'h00, 0, 0);
    do_job("bp_blend", 8'h5A, 11, 33, 44, 8'hC3, 5, 1);
    do_job("bp_opaque", 8'h3C, 15, 1, 2, 8'h00, 5, 0);

    // Reset while waiting for read data; a later stale return must be ignored.
    in_valid = 1'b1; in_pxl = 8'h77; in_alpha = 4'd5; in_posx = 10'd7; in_posy = 9'd9;
    gw_ready = 1'b1;
    @(negedge clk_ir);
    in_valid = 1'b0;
    @(negedge clk_ir);
    check("rst_mid_in_wait", {busy, gw_rd_valid}, 2'b10);
    begin
      int wr0;
      wr0 = wr_cnt;
      rst_sync = 1'b1;
      @(negedge clk_ir);
      rst_sync = 1'b0;
      rd_valid = 1'b1;
      rd_pxl   = 8'h11;
      @(negedge clk_ir);
      rd_valid = 1'b0;
      repeat (3) @(negedge clk_ir);
      check("rst_mid_idle", {in_ready, busy, gw_wr_valid, gw_rd_valid}, 4'b1000);
      check("rst_mid_no_wr", wr_cnt - wr0, 0);
    end

`ifdef SYN_GPU_PXL_BLEND_RD_TMO_EN
    in_valid = 1'b1; in_pxl = 8'h12; in_alpha = 4'd3; in_posx = 10'd1; in_posy = 9'd1;
    @(negedge clk_ir);
    in_valid = 1'b0;
    @(negedge clk_ir);
    begin
      int wr0;
      wr0 = wr_cnt;
      repeat (63) @(negedge clk_ir);
      check("tmo_before", {busy, err_rd_tmo}, 2'b10);
      @(negedge clk_ir);
      check("tmo_after", {busy, in_ready, err_rd_tmo}, 3'b011);
      rd_valid = 1'b1;
      @(negedge clk_ir);
      rd_valid = 1'b0;
      repeat (2) @(negedge clk_ir);
      check("tmo_late_rd", {busy, err_rd_tmo, 8'(wr_cnt - wr0)}, {2'b01, 8'd0});
    end
`else
    check("tmo_tied_off", err_rd_tmo, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      a = $urandom_range(0, 15);
      x = (($urandom_range(0, 7)) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639);
      y = (($urandom_range(0, 7)) == 0) ? $urandom_range(480, 511) : $urandom_range(0, 479);
      do_job($sformatf("rand%0d", n), 8'($urandom), a, x, y, 8'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 3));
    end

    check("never_rd_and_wr", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/syn_gpu_pxl_blend.md
Name: syn_gpu_pxl_blend

Overview:
- Alpha-blend stage directly upstream of the GPU pixel gateway.
- Accepts one pixel-write job at a time from the GPU core: pixel, alpha, posx, posy.
- For translucent alpha it reads the current pixel through the gateway, blends the new pixel over it, and writes the result back.
- Drives the gateway's pixel transfer port and consumes its read-return port.

Parameters:
- P_X_W, 10, posx width
- P_Y_W, 9, posy width
- P_CANVAS_W, 640, canvas width in pixels
- P_CANVAS_H, 480, canvas height in pixels
- P_H_W, 3, hue field width
- P_S_W, 2, saturation field width
- P_I_W, 3, intensity field width. Pixel is packed {h,s,i}, with i in the LSBs; P_PXL_W = P_H_W+P_S_W+P_I_W.
- P_RD_TMO, 64, read-return timeout in cycles (optional feature only)

Ports:
- clk_ir  in  1  clock
- rst_sync  in  1  synchronous reset, active-high
- in_valid  in  1  job valid
- in_ready  out  1  job accepted when in_valid & in_ready
- in_pxl  in  P_PXL_W  source pixel
- in_alpha  in  4  opacity: 0 = transparent, 15 = opaque
- in_posx  in  P_X_W  x position
- in_posy  in  P_Y_W  y position
- gw_pxl  out  P_PXL_W  write pixel to gateway
- gw_wr_valid  out  1  write request
- gw_rd_valid  out  1  read request
- gw_posx  out  P_X_W  request x
- gw_posy  out  P_Y_W  request y
- gw_ready  in  1  gateway accepts request this cycle
- rd_valid  in  1  read data valid, from gateway
- rd_pxl  in  P_PXL_W  read data
- busy  out  1  state != IDLE
- err_rd_tmo  out  1  sticky read-timeout flag (optional feature)

Behaviour:
- Reset values: all outputs 0 except in_ready = 1; state IDLE; job registers cleared.
- Reset mid-operation: abort the job immediately, return to IDLE, issue no further requests.
- rd_valid arriving outside RD_WAIT, including a stale return after reset, is ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- in_ready = (state == IDLE). On accept, latch pxl, alpha, posx, posy.
- Accept with alpha = 0, or posx >= P_CANVAS_W, or posy >= P_CANVAS_H: drop the job, stay IDLE, issue no gateway transaction.
- Accept with alpha = 15: go to WR_REQ with gw_pxl = in_pxl; no read is issued.
- Accept with alpha 1..14: go to RD_REQ.
- RD_REQ: gw_rd_valid = 1; posx/posy held stable until gw_ready = 1, then go to RD_WAIT.
- RD_WAIT: on rd_valid, compute and register the blended pixel, then go to WR_REQ.
- Blend, intensity field:
  - i_out = (i_old*(16-a) + i_new*a + 8) >> 4
  - intermediate width P_I_W+5; result never exceeds max, so no saturation logic.
- Blend, h and s fields: taken from in_pxl if alpha >= 8, else from rd_pxl.
- WR_REQ: gw_wr_valid = 1; gw_pxl, gw_posx, gw_posy held stable until gw_ready = 1, then go to IDLE. in_ready is high the following cycle.
- gw_wr_valid and gw_rd_valid are never high together. Each is held until gw_ready.
- Latency, opaque job with gw_ready = 1: accept cycle N, gw_wr_valid at N+1, in_ready at N+2.
- Latency, blend job: accept N; read request at N+1; read return at R; write request at R+1; in_ready at R+2.
- gw outputs are registered (no combinational path from in_* to gw_*). gw_posx/gw_posy drive 0 in IDLE.

Optional Feature:
- Macro SYN_GPU_PXL_BLEND_RD_TMO_EN.
- Defined:
  - Counter starts on entry to RD_WAIT.
  - If no rd_valid within P_RD_TMO cycles, set err_rd_tmo (sticky until rst_sync), drop the job, return to IDLE; no write is issued.
  - A late rd_valid is then ignored.
- Undefined: RD_WAIT waits indefinitely; err_rd_tmo tied to 0; no counter logic.

Test Plan:
- Opaque: in_pxl = 8'hFF, alpha 15, pos (10,20), gw_ready = 1 -> single gw_wr_valid pulse next cycle with gw_pxl = 8'hFF, gw_posx = 10, gw_posy = 20; no gw_rd_valid.
- Blend, new h/s: old {h5,s1,i0}, new {h2,s3,i7}, alpha 8 -> write gw_pxl = {h2,s3,i4}.
- Blend, old h/s: old {h5,s1,i6}, new {h2,s3,i2}, alpha 4 -> write {h5,s1,i5}, since (72+8+8)>>4 = 5.
- Drop: posx = 640 or alpha 0 -> no gw request; in_ready stays 1; busy stays 0.
- Backpressure: gw_ready low 5 cycles during RD_REQ and WR_REQ -> requests and positions held stable; exactly one read and one write accepted.
- Reset/timeout: rst_sync asserted in RD_WAIT, then rd_valid -> IDLE, no write. With SYN_GPU_PXL_BLEND_RD_TMO_EN and no rd_valid -> err_rd_tmo = 1 after 64 cycles, FSM returns to IDLE.
